// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_if
// Description : Bundle between the pipeline and the general-purpose register
//               file. It carries the write-back bundle (we/waddr/wdata), two
//               decode read ports, one debug read port and the retired-write
//               counter.
//               master : pipeline side. It drives the write bundle, the read
//                        addresses and enables, and the debug address.
//               slave  : register file side. It returns the read data, the
//                        debug data and wr_count.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [31:0]       wr_count;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, wr_count
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, wr_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : General-purpose register file with 2^ADDR_W entries. Register
//               0 always reads as zero. There are two combinational read ports
//               with a write-through bypass and one debug read port that has
//               no bypass. A wrapping 32-bit counter records committed writes.
// Ports       : clk - system clock; all state changes on the rising edge
//               rst - synchronous, active-high reset
//               bus - regfile_if.slave (write bundle, read ports, debug port,
//                     wr_count)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic  clk,
    input  wire logic  rst,
    regfile_if.slave   bus
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [31:0]       r_wr_count;
    logic              w_wr_fire;

    // A write commits only outside reset and only to a non-zero address.
    // Writes to r0 are dropped, and they are not counted.
    assign w_wr_fire = !rst && bus.we && (bus.waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_fire) begin
            r_mem[bus.waddr] <= bus.wdata;
            r_wr_count       <= r_wr_count + 32'd1;
        end
    end

    // Decode read port. The checks run in priority order: reset, then r0,
    // then the write-through bypass, then storage, then disabled.
    function automatic logic [DATA_W-1:0] f_read_port(
        input logic              rst_i,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (rst_i) begin
            v = '0;
        end else if (raddr == '0) begin
            v = '0;
        end else if (re && we && (raddr == waddr)) begin
            v = wdata;
        end else if (re) begin
            v = stored;
        end else begin
            v = '0;
        end
        return v;
    endfunction

    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_dbg_data;

    always_comb begin
        w_rdata1 = f_read_port(rst, bus.re1, bus.raddr1, bus.we, bus.waddr,
                               bus.wdata, r_mem[bus.raddr1]);
        w_rdata2 = f_read_port(rst, bus.re2, bus.raddr2, bus.we, bus.waddr,
                               bus.wdata, r_mem[bus.raddr2]);
    end

    // The debug port returns the stored value only. An in-flight write
    // becomes visible here one cycle later.
    always_comb begin
        w_dbg_data = '0;
        if (!rst && (bus.dbg_addr != '0)) begin
            w_dbg_data = r_mem[bus.dbg_addr];
        end
    end

    assign bus.rdata1   = w_rdata1;
    assign bus.rdata2   = w_rdata2;
    assign bus.dbg_data = w_dbg_data;
    assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile
// Description : Self-checking bench for regfile. It runs directed scenarios
//               and then randomized traffic, and compares every output with
//               an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile;

    logic clk;
    logic rst;

    regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_mem [32];
    logic [31:0] m_cnt;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
        if (rst)                                 return 32'h0;
        if (a == 5'd0)                           return 32'h0;
        if (re && bus.we && a == bus.waddr)      return bus.wdata;
        if (re)                                  return m_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_dbg();
        if (rst || bus.dbg_addr == 5'd0) return 32'h0;
        return m_mem[bus.dbg_addr];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rd1"}, bus.rdata1,   m_read(bus.re1, bus.raddr1));
        chk({tag, ".rd2"}, bus.rdata2,   m_read(bus.re2, bus.raddr2));
        chk({tag, ".dbg"}, bus.dbg_data, m_dbg());
        chk({tag, ".cnt"}, bus.wr_count, m_cnt);
    endtask

    // Advance one clock. The model follows the DUT, and the task returns at
    // the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            m_cnt = 32'h0;
        end else if (bus.we && bus.waddr != 5'd0) begin
            m_mem[bus.waddr] = bus.wdata;
            m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.re1 = 1'b0; bus.raddr1 = '0;
        bus.re2 = 1'b0; bus.raddr2 = '0;
        bus.dbg_addr = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'hx;
        m_cnt = 32'hx;
        rst = 1'b1;
        idle_inputs();

        // Reset held for 2 cycles, then every address is read on both ports.
        tick();
        tick();
        chk("rst.rd1", bus.rdata1, 32'h0);
        chk("rst.cnt", bus.wr_count, 32'h0);
        rst = 1'b0;
        bus.re1 = 1'b1; bus.re2 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.raddr1 = 5'(a); bus.raddr2 = 5'(31 - a); bus.dbg_addr = 5'(a);
            #1;
            chk("clr.rd1", bus.rdata1, 32'h0);
            chk("clr.rd2", bus.rdata2, 32'h0);
            chk("clr.dbg", bus.dbg_data, 32'h0);
        end
        chk("clr.cnt", bus.wr_count, 32'h0);

        // Basic write, then read in the following cycle.
        idle_inputs();
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
        tick();
        idle_inputs();
        bus.re1 = 1'b1; bus.raddr1 = 5'd5; bus.dbg_addr = 5'd5;
        #1;
        chk("wr.rd1", bus.rdata1, 32'hDEADBEEF);
        chk("wr.dbg", bus.dbg_data, 32'hDEADBEEF);
        chk("wr.cnt", bus.wr_count, 32'd1);

        // Bypass: both ports see wdata in the write cycle. The debug port
        // still shows the old value.
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
        bus.re1 = 1'b1; bus.re2 = 1'b1; bus.raddr1 = 5'd7; bus.raddr2 = 5'd7;
        bus.dbg_addr = 5'd7;
        #1;
        chk("byp.rd1", bus.rdata1, 32'h12345678);
        chk("byp.rd2", bus.rdata2, 32'h12345678);
        chk("byp.dbg", bus.dbg_data, 32'h0);
        tick();
        bus.we = 1'b0;
        #1;
        chk("byp.dbg2", bus.dbg_data, 32'h12345678);
        chk("byp.cnt", bus.wr_count, 32'd2);

        // A write to r0 is discarded and leaves the counter unchanged.
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
        bus.raddr1 = 5'd0; bus.raddr2 = 5'd0; bus.dbg_addr = 5'd0;
        #1;
        chk("r0.rd1", bus.rdata1, 32'h0);
        chk("r0.rd2", bus.rdata2, 32'h0);
        tick();
        chk("r0.cnt", bus.wr_count, 32'd2);

        // Read disable, then a write presented during reset is dropped.
        idle_inputs();
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        bus.re1 = 1'b0; bus.raddr1 = 5'd3;
        bus.re2 = 1'b1; bus.raddr2 = 5'd3;
        #1;
        chk("dis.rd1", bus.rdata1, 32'h0);
        chk("dis.rd2", bus.rdata2, 32'hA5A5A5A5);
        rst = 1'b1;
        bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h1;
        bus.re1 = 1'b1; bus.dbg_addr = 5'd3;
        #1;
        chk("rsw.rd2", bus.rdata2, 32'h0);
        chk("rsw.dbg", bus.dbg_data, 32'h0);
        tick();
        rst = 1'b0;
        idle_inputs();
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        bus.re2 = 1'b1; bus.raddr2 = 5'd4;
        #1;
        chk("rsd.r3", bus.rdata1, 32'h0);
        chk("rsd.r4", bus.rdata2, 32'h0);
        chk("rsd.cnt", bus.wr_count, 32'h0);

        // Counter wrap: the counter is preloaded to all-ones, then one write
        // is made.
        force dut.r_wr_count = 32'hFFFFFFFF;
        #1;
        release dut.r_wr_count;
        m_cnt = 32'hFFFFFFFF;
        #1;
        chk("wrap.pre", bus.wr_count, 32'hFFFFFFFF);
        bus.we = 1'b1; bus.waddr = 5'd1; bus.wdata = 32'h0BADF00D;
        tick();
        chk("wrap.cnt", bus.wr_count, 32'h0);
        bus.we = 1'b0; bus.re1 = 1'b1; bus.raddr1 = 5'd1;
        #1;
        chk("wrap.r1", bus.rdata1, 32'h0BADF00D);

        // Randomized traffic. Small address ranges make bypass hits and
        // rewrites frequent.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.we    = $urandom_range(0, 3) != 0;
            bus.waddr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            bus.wdata = $urandom;
            bus.re1   = $urandom_range(0, 5) != 0;
            bus.re2   = $urandom_range(0, 5) != 0;
            bus.raddr1 = ($urandom_range(0, 2) == 0) ? bus.waddr : 5'($urandom_range(0, 7));
            bus.raddr2 = ($urandom_range(0, 2) == 0) ? bus.waddr : 5'($urandom);
            bus.dbg_addr = ($urandom_range(0, 2) == 0) ? bus.waddr : 5'($urandom_range(0, 7));
            #1;
            check_all("rnd");
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
